// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiplier issue controller.
// Op encodings, controller states and default core latency.
package mul_ctrl_pkg;

  localparam logic [1:0] OP_MULW   = 2'b00;
  localparam logic [1:0] OP_MULHW  = 2'b01;
  localparam logic [1:0] OP_MULHWU = 2'b10;

  localparam int MUL_LAT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_RESP
  } mul_state_t;

  // Only MULH.WU runs the core unsigned.
  function automatic logic op_signed(
    input logic [1:0] op
  );
    return op != OP_MULHWU;
  endfunction

  // Reserved op 11 falls back to the low half like MUL.W.
  function automatic logic op_high(
    input logic [1:0] op
  );
    return (op == OP_MULHW) || (op == OP_MULHWU);
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// Single-entry product cache keyed on (src1, src2, sign).
// Lets a MUL.W/MULH pair on equal operands share one core pass.
module mul_result_cache
  import mul_ctrl_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_src1,
  input  logic [31:0] wr_src2,
  input  logic        wr_sign,
  input  logic [63:0] wr_prod,
  input  logic [31:0] lk_src1,
  input  logic [31:0] lk_src2,
  input  logic        lk_sign,
  input  logic        lk_high,
  output logic        hit,
  output logic [31:0] rd_data
);

  logic        vld;
  logic [31:0] tag_src1;
  logic [31:0] tag_src2;
  logic        tag_sign;
  logic [63:0] prod;

  logic        ops_eq;
  logic        sign_ok;

  always_ff @(posedge mul_clk) begin
    if (!reset) begin
      vld      <= 1'b0;
      tag_src1 <= '0;
      tag_src2 <= '0;
      tag_sign <= 1'b0;
      prod     <= '0;
    end else if (wr_en) begin
      vld      <= 1'b1;
      tag_src1 <= wr_src1;
      tag_src2 <= wr_src2;
      tag_sign <= wr_sign;
      prod     <= wr_prod;
    end
  end

  // The low half does not depend on signedness.
  assign ops_eq  = (tag_src1 == lk_src1)
                 && (tag_src2 == lk_src2);
  assign sign_ok = !lk_high || (tag_sign == lk_sign);

  assign hit = (CACHE_EN != 0)
             && vld
             && ops_eq
             && sign_ok;

  assign rd_data = lk_high ? prod[63:32]
                           : prod[31:0];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/response sequencer for the shared two-stage multiplier core.
// Fixed-latency capture, one-entry product cache, flush-safe drain.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int CACHE_EN = 1
) (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result
);

  localparam int CW = (MUL_LAT > 2)
                    ? $clog2(MUL_LAT) : 1;

  mul_state_t  state;
  logic [CW-1:0] cnt;

  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic        op_sign_r;
  logic        op_high_r;

  logic        accept;
  logic        lk_sign;
  logic        lk_high;
  logic        c_hit;
  logic [31:0] c_data;
  logic        done;
  logic        c_wr;
  logic [31:0] res_half;

  assign lk_sign = op_signed(req_op);
  assign lk_high = op_high(req_op);

  assign req_ready = reset
                   && (state == ST_IDLE)
                   && !flush;
  assign accept    = req_valid && req_ready;

  assign done = (cnt == '0);
  assign c_wr = (state == ST_WAIT)
              && done
              && !flush;

  assign res_half = op_high_r ? mul_result[63:32]
                              : mul_result[31:0];

  mul_result_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .mul_clk (mul_clk),
    .reset   (reset),
    .wr_en   (c_wr),
    .wr_src1 (op_src1),
    .wr_src2 (op_src2),
    .wr_sign (op_sign_r),
    .wr_prod (mul_result),
    .lk_src1 (req_src1),
    .lk_src2 (req_src2),
    .lk_sign (lk_sign),
    .lk_high (lk_high),
    .hit     (c_hit),
    .rd_data (c_data)
  );

  always_ff @(posedge mul_clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_src1   <= '0;
      op_src2   <= '0;
      op_sign_r <= 1'b0;
      op_high_r <= 1'b0;
      resp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_src1   <= req_src1;
            op_src2   <= req_src2;
            op_sign_r <= lk_sign;
            op_high_r <= lk_high;
            if (c_hit) begin
              resp_data <= c_data;
              state     <= ST_RESP;
            end else begin
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= CW'(MUL_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The core finishes on its own; a flush
          // only suppresses the response.
          if (done) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              resp_data <= res_half;
              state     <= ST_RESP;
            end
          end else begin
            cnt <= cnt - CW'(1);
            if (flush) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (done) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (flush || resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign mul_start  = (state == ST_ISSUE) && !flush;
  assign mul_sign   = op_sign_r;
  assign mul_x      = op_src1;
  assign mul_y      = op_src2;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural core model, vector table,
// response scoreboard and hand-written flush/backpressure/reset cases.
module tb_mul_issue_ctrl;

  localparam int LAT = 4;

  logic        mul_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic        mul_start;
  logic        mul_sign;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result;

  mul_issue_ctrl #(
    .MUL_LAT  (LAT),
    .CACHE_EN (1)
  ) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_sign   (mul_sign),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_result (mul_result)
  );

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  int cyc = 0;
  always @(posedge mul_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Core model: operands read at S+2, product shown from S+LAT.
  int          rem = 0;
  logic [63:0] prod_r;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic s
  );
    logic [63:0] ex;
    logic [63:0] ey;
    ex = s ? {{32{x[31]}}, x} : {32'd0, x};
    ey = s ? {{32{y[31]}}, y} : {32'd0, y};
    return ex * ey;
  endfunction

  always @(posedge mul_clk) begin
    if (!reset) begin
      rem        <= 0;
      mul_result <= '0;
    end else if (mul_start) begin
      rem        <= LAT - 1;
      mul_result <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (rem == 2)
        prod_r <= ref_mul(mul_x, mul_y, mul_sign);
      if (rem == 1)
        mul_result <= prod_r;
    end
  end

  int   start_cnt = 0;
  int   last_start_cyc = -1;
  logic last_start_sign = 1'b0;

  always @(negedge mul_clk) begin
    if (mul_start) begin
      start_cnt++;
      last_start_cyc  = cyc;
      last_start_sign = mul_sign;
    end
  end

  logic [31:0] sb[$];

  always @(negedge mul_clk) begin
    if (reset && resp_valid && resp_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected none",
                 resp_data);
      end else begin
        chk("sb_data", {32'd0, resp_data},
            {32'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      output int acc);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge mul_clk);
      if (req_ready) break;
    end
    chk("send_ready", {63'd0, req_ready}, 64'd1);
    acc = cyc;
    @(posedge mul_clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int acc,
                           input int lat,
                           input string nm);
    int got;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge mul_clk);
      if (resp_valid) begin
        got = cyc - acc;
        break;
      end
    end
    chk(nm, 64'(got), 64'(lat));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp;
    int          lat;
    logic        sign;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int s0;

    vt[0] = '{2'b00, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFA, 6, 1'b1};
    vt[1] = '{2'b01, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFF, 1, 1'b1};
    vt[2] = '{2'b10, 32'h3, 32'hFFFFFFFE, 32'h00000002, 6, 1'b0};
    vt[3] = '{2'b00, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFA, 1, 1'b0};
    vt[4] = '{2'b01, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFF, 6, 1'b1};
    vt[5] = '{2'b11, 32'h7, 32'h9, 32'h0000003F, 6, 1'b1};
    vt[6] = '{2'b01, 32'h80000000, 32'h80000000,
              32'h40000000, 6, 1'b1};
    vt[7] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 6, 1'b0};
    vt[8] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000001, 1, 1'b0};
    vt[9] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000000, 6, 1'b1};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_src1   = '0;
    req_src2   = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;

    repeat (3) @(posedge mul_clk);
    @(negedge mul_clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge mul_clk);
    #1 reset = 1'b1;
    @(negedge mul_clk);
    chk("rst_req_ready_idle", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_start", {63'd0, mul_start}, 64'd0);
    chk("rst_sign", {63'd0, mul_sign}, 64'd0);
    chk("rst_xy", {mul_x, mul_y}, 64'd0);
    @(posedge mul_clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      s0 = start_cnt;
      send(vt[i].op, vt[i].s1, vt[i].s2, acc);
      sb.push_back(vt[i].exp);
      wait_resp(acc, vt[i].lat,
                $sformatf("v%0d_lat", i));
      chk($sformatf("v%0d_starts", i),
          64'(start_cnt - s0),
          (vt[i].lat == 1) ? 64'd0 : 64'd1);
      if (vt[i].lat != 1) begin
        chk($sformatf("v%0d_start_cyc", i),
            64'(last_start_cyc), 64'(acc + 1));
        chk($sformatf("v%0d_sign", i),
            {63'd0, last_start_sign},
            {63'd0, vt[i].sign});
      end
      @(posedge mul_clk);
      #1;
    end

    // Backpressure held in RESP.
    resp_ready = 1'b0;
    send(2'b00, 32'd5, 32'd6, acc);
    sb.push_back(32'h1E);
    wait_resp(acc, 6, "bp_lat");
    s0 = start_cnt;
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_data", {32'd0, resp_data}, 64'h1E);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge mul_clk);
    end
    chk("bp_starts", 64'(start_cnt - s0), 64'd0);
    @(posedge mul_clk);
    #1 resp_ready = 1'b1;
    @(posedge mul_clk);
    @(negedge mul_clk);
    chk("bp_idle_busy", {63'd0, busy}, 64'd0);
    chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);
    @(posedge mul_clk);
    #1;

    // Flush at A+3 while waiting on the core.
    s0 = start_cnt;
    send(2'b00, 32'd11, 32'd13, acc);
    @(posedge mul_clk);
    #1;
    @(posedge mul_clk);
    #1 flush = 1'b1;
    @(posedge mul_clk);
    #1 flush = 1'b0;
    @(negedge mul_clk);
    chk("fl_ready_a4", {63'd0, req_ready}, 64'd0);
    chk("fl_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge mul_clk);
    chk("fl_ready_a5", {63'd0, req_ready}, 64'd0);
    @(negedge mul_clk);
    chk("fl_ready_a6", {63'd0, req_ready}, 64'd1);
    chk("fl_cyc_a6", 64'(cyc - acc), 64'd6);
    chk("fl_starts", 64'(start_cnt - s0), 64'd1);
    @(posedge mul_clk);
    #1;
    s0 = start_cnt;
    send(2'b00, 32'd11, 32'd13, acc);
    sb.push_back(32'd143);
    wait_resp(acc, 6, "fl_reissue_lat");
    chk("fl_reissue_starts", 64'(start_cnt - s0), 64'd1);
    @(posedge mul_clk);
    #1;

    // Reset while in WAIT.
    send(2'b00, 32'd21, 32'd2, acc);
    @(posedge mul_clk);
    #1;
    @(posedge mul_clk);
    #1 reset = 1'b0;
    @(negedge mul_clk);
    chk("mr_req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge mul_clk);
    #1 reset = 1'b1;
    @(negedge mul_clk);
    chk("mr_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("mr_resp_data", {32'd0, resp_data}, 64'd0);
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_start", {63'd0, mul_start}, 64'd0);
    chk("mr_sign", {63'd0, mul_sign}, 64'd0);
    chk("mr_xy", {mul_x, mul_y}, 64'd0);
    chk("mr_req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge mul_clk);
    #1;
    s0 = start_cnt;
    send(2'b00, 32'd11, 32'd13, acc);
    sb.push_back(32'd143);
    wait_resp(acc, 6, "mr_miss_lat");
    chk("mr_miss_starts", 64'(start_cnt - s0), 64'd1);

    repeat (3) @(posedge mul_clk);
    @(negedge mul_clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
